// File: rtl/fwd_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard controller.
package fwd_ctrl_pkg;

  // Default register-file address width (32 architectural registers).
  localparam int DEF_REG_ADDR_W = 5;

  // Operand mux select encoding; 2'b11 is never driven.
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,  // register-file operand captured in ID/EX
    FWD_EXMEM = 2'b01,  // ALU result sitting in EX/MEM
    FWD_MEMWB = 2'b10   // writeback data sitting in MEM/WB
  } fwd_sel_e;

endpackage

// File: rtl/fwd_src_sel.sv
// Per-operand forwarding priority resolver. Looks at one ID source register
// and the EX/MEM shadow stages and decides where the operand must come from.
// It also flags a load in EX that produces this source (a load-use hazard).
module fwd_src_sel
  import fwd_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  src_used,
  input  logic                  ex_valid,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic                  mem_valid,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  output logic [1:0]            sel,
  output logic                  load_hit
);

  logic src_live_s;
  logic ex_hit_s;
  logic mem_hit_s;

  // Register 0 is hard-wired to zero, so it never matches a producer.
  assign src_live_s = src_used & (src != {REG_ADDR_W{1'b0}});
  assign ex_hit_s   = src_live_s & ex_valid  & ex_regwrite  & (ex_dst  == src);
  assign mem_hit_s  = src_live_s & mem_valid & mem_regwrite & (mem_dst == src);

  // Youngest producer wins; a load in EX cannot forward (its data is not
  // ready yet), the controller stalls instead and retries one cycle later.
  always_comb begin
    sel      = FWD_REG;
    load_hit = ex_hit_s & ex_memread;
    if (ex_hit_s && !ex_memread) begin
      sel = FWD_EXMEM;
    end else if (mem_hit_s) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_REG;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Keeps a private shadow of the destination info of instructions in EX and
// MEM, drives registered ALU operand mux selects, and raises a combinational
// one-cycle stall (with bubble insertion) on load-use hazards.
// A WB-stage writer never needs forwarding because the register file is
// write-first, so the shadow only needs to reach the MEM stage.
module fwd_ctrl
  import fwd_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_hold,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  // EX shadow stage
  logic                  ex_valid_r;
  logic [REG_ADDR_W-1:0] ex_dst_r;
  logic                  ex_regwrite_r;
  logic                  ex_memread_r;
  // MEM shadow stage (the load flag is not needed past EX)
  logic                  mem_valid_r;
  logic [REG_ADDR_W-1:0] mem_dst_r;
  logic                  mem_regwrite_r;

  logic [1:0]            fwd_a_sel_r;
  logic [1:0]            fwd_b_sel_r;
  logic [CNT_W-1:0]      stall_count_r;

  logic [1:0]            a_sel_s;
  logic [1:0]            b_sel_s;
  logic                  a_load_hit_s;
  logic                  b_load_hit_s;
  logic                  stall_s;
  logic                  issue_s;

  fwd_src_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_rs (
    .src          (id_rs),
    .src_used     (id_uses_rs),
    .ex_valid     (ex_valid_r),
    .ex_regwrite  (ex_regwrite_r),
    .ex_memread   (ex_memread_r),
    .ex_dst       (ex_dst_r),
    .mem_valid    (mem_valid_r),
    .mem_regwrite (mem_regwrite_r),
    .mem_dst      (mem_dst_r),
    .sel          (a_sel_s),
    .load_hit     (a_load_hit_s)
  );

  fwd_src_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_rt (
    .src          (id_rt),
    .src_used     (id_uses_rt),
    .ex_valid     (ex_valid_r),
    .ex_regwrite  (ex_regwrite_r),
    .ex_memread   (ex_memread_r),
    .ex_dst       (ex_dst_r),
    .mem_valid    (mem_valid_r),
    .mem_regwrite (mem_regwrite_r),
    .mem_dst      (mem_dst_r),
    .sel          (b_sel_s),
    .load_hit     (b_load_hit_s)
  );

  // Load-use hazard is visible in the same cycle; the ID instruction only
  // moves into EX when it is real and not stalled.
  assign stall_s = id_valid & (a_load_hit_s | b_load_hit_s);
  assign issue_s = id_valid & ~stall_s;

  // Shadow pipeline: EX takes the ID instruction or a bubble, MEM follows EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_r     <= 1'b0;
      ex_dst_r       <= {REG_ADDR_W{1'b0}};
      ex_regwrite_r  <= 1'b0;
      ex_memread_r   <= 1'b0;
      mem_valid_r    <= 1'b0;
      mem_dst_r      <= {REG_ADDR_W{1'b0}};
      mem_regwrite_r <= 1'b0;
    end else if (!pipe_hold) begin
      if (issue_s) begin
        ex_valid_r    <= 1'b1;
        ex_dst_r      <= id_dst;
        ex_regwrite_r <= id_regwrite;
        ex_memread_r  <= id_memread;
      end else begin
        ex_valid_r    <= 1'b0;
        ex_dst_r      <= {REG_ADDR_W{1'b0}};
        ex_regwrite_r <= 1'b0;
        ex_memread_r  <= 1'b0;
      end
      mem_valid_r    <= ex_valid_r;
      mem_dst_r      <= ex_dst_r;
      mem_regwrite_r <= ex_regwrite_r;
    end
  end

  // Operand selects travel with the instruction into EX; bubbles get 00.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a_sel_r <= FWD_REG;
      fwd_b_sel_r <= FWD_REG;
    end else if (!pipe_hold) begin
      if (issue_s) begin
        fwd_a_sel_r <= a_sel_s;
        fwd_b_sel_r <= b_sel_s;
      end else begin
        fwd_a_sel_r <= FWD_REG;
        fwd_b_sel_r <= FWD_REG;
      end
    end
  end

  // Saturating count of effective (non-held) load-use stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_r <= {CNT_W{1'b0}};
    end else if (!pipe_hold && stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
      stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign fwd_a_sel   = fwd_a_sel_r;
  assign fwd_b_sel   = fwd_b_sel_r;
  assign stall       = stall_s;
  assign stall_count = stall_count_r;

endmodule
